// File: rtl/benes_cfg_streamer.sv
// benes_cfg_streamer: transmit side of the Benes switch-configuration link.
// Holds a table of switch-control words and streams them onto s_sig with a
// valid/ready handshake while holding configure high, then waits for the
// receiver's done and reports completion and the elapsed cycle count.
//
// Optional feature macro: BENES_CFG_TIMEOUT_EN
//   defined   -> DRAIN gives up after TIMEOUT cycles, sets err, pulses done
//   undefined -> DRAIN waits for done_in indefinitely (no timeout counter)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; table writable
// STREAM | configure=1, s_valid=1, one word per accepted handshake
// DRAIN  | all words sent, configure=1, waiting for receiver done_in
// DONE   | one-cycle done pulse, configure=0, back to IDLE
module benes_cfg_streamer #(
  parameter int SW      = 10,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_sig,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [SW-1:0] wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic [SW-1:0] s_sig,
  output logic          s_valid,
  input  logic          s_ready,
  output logic          configure,
  input  logic          done_in,
  output logic          done,
  output logic          busy,
  output logic          err,
  output logic [31:0]   n_c
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Reject parameter sets the address/timeout logic cannot represent.
  if (DEPTH > (1 << AW) || DEPTH < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("benes_cfg_streamer: DEPTH must fit in AW bits and TIMEOUT must be >= 1");
  end

  state_t          state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   s_sig_q, s_sig_d;
  logic            early_q, early_d;
  logic            err_q, err_d;
  logic [31:0]     n_c_q, n_c_d;
  logic [SW-1:0]   mem_q [DEPTH];

  logic [AW:0]     len_clamp;
  logic            last_word;
  logic [31:0]     n_c_inc;

`ifdef BENES_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  assign len_clamp = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign last_word = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
  assign n_c_inc   = (n_c_q == 32'hFFFF_FFFF) ? n_c_q : n_c_q + 32'd1;

  // Next-state, datapath updates and the error flag.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    s_sig_d = s_sig_q;
    early_d = early_q;
    err_d   = err_q;
    n_c_d   = n_c_q;
`ifdef BENES_CFG_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          idx_d   = '0;
          s_sig_d = mem_q[0];
          early_d = 1'b0;
          err_d   = 1'b0;
          // The start cycle itself counts toward n_c.
          n_c_d   = 32'd1;
          state_d = (len_clamp == '0) ? ST_DONE : ST_STREAM;
        end
      end

      ST_STREAM: begin
        n_c_d = n_c_inc;
        if (done_in) early_d = 1'b1;
        if (s_ready) begin
          if (last_word) begin
            // A done_in arriving on the final handshake also counts as early.
            state_d = (early_q || done_in) ? ST_DONE : ST_DRAIN;
`ifdef BENES_CFG_TIMEOUT_EN
            tmo_d   = TW'(TIMEOUT - 1);
`endif
          end else begin
            idx_d   = idx_q + AW'(1);
            s_sig_d = mem_q[idx_q + AW'(1)];
          end
        end
      end

      ST_DRAIN: begin
        n_c_d = n_c_inc;
        if (done_in) begin
          state_d = ST_DONE;
`ifdef BENES_CFG_TIMEOUT_EN
        end else if (tmo_q == '0) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q - TW'(1);
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Table writes are only honoured in IDLE; anything else is flagged.
    if (wr_en && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      s_sig_q <= '0;
      early_q <= 1'b0;
      err_q   <= 1'b0;
      n_c_q   <= '0;
`ifdef BENES_CFG_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      s_sig_q <= s_sig_d;
      early_q <= early_d;
      err_q   <= err_d;
      n_c_q   <= n_c_d;
`ifdef BENES_CFG_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Switch-word table; contents deliberately survive reset.
  always_ff @(posedge clk_sig) begin
    if (wr_en && (state_q == ST_IDLE)) mem_q[wr_addr] <= wr_data;
  end

  assign s_sig     = s_sig_q;
  assign s_valid   = (state_q == ST_STREAM);
  assign configure = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign n_c       = n_c_q;

endmodule
